// File: rtl/lcd_cmd_sched.sv
// lcd_cmd_sched: buffers host opcodes and issues them one at a time to the LCD image controller.
// Latency: push into an empty FIFO -> lcd_cmd_valid 2 cycles later; done sampled -> next issue 2 cycles later.
// Backpressure: host_ready drops only when the FIFO is full; the controller side is paced by busy/done.
//
// Ports:
//   clk, reset                   single clock, asynchronous active-high reset
//   host_cmd/host_valid/host_ready  host push interface (opcodes 12-15 are accepted then discarded)
//   lcd_busy/lcd_done            controller status inputs
//   lcd_cmd/lcd_cmd_valid        registered opcode and one-cycle issue strobe to the controller
//   fifo_level, cmd_count        queue occupancy and completed-command counter (wraps)
//   illegal_cmd, timeout_err     illegal-opcode pulse and handshake-timeout flag
//   err_clr, idle                error acknowledge and "nothing to do" status
module lcd_cmd_sched #(
  parameter int FIFO_DEPTH   = 8,
  parameter int ACK_TIMEOUT  = 15,
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    host_cmd,
  input  logic                          host_valid,
  output logic                          host_ready,
  input  logic                          lcd_busy,
  input  logic                          lcd_done,
  output logic [3:0]                    lcd_cmd,
  output logic                          lcd_cmd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    cmd_count,
  output logic                          illegal_cmd,
  output logic                          timeout_err,
  input  logic                          err_clr,
  output logic                          idle
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int TMAX = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ACK_LIM  = CW'(ACK_TIMEOUT);
  localparam logic [CW-1:0] DONE_LIM = CW'(DONE_TIMEOUT);

  typedef enum logic [2:0] {
    BOOT,
    READY,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    ERR
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] tmo_inc;

  logic          push;
  logic          push_legal;
  logic          pop;
  logic          cnt_clr;
  logic          done_ok;

  assign host_ready = (fifo_level != LVL_FULL);
  assign push       = host_valid && host_ready;
  // Opcodes 12-15 complete the handshake but never reach the queue.
  assign push_legal = push && (host_cmd < 4'd12);
  assign tmo_inc    = tmo_cnt + 1'b1;

  assign timeout_err = (state == ERR);
  assign idle        = (state == READY) && (fifo_level == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cnt_clr   = 1'b0;
    done_ok   = 1'b0;
    case (state)
      BOOT: begin
        if (!lcd_busy) state_nxt = READY;
      end
      READY: begin
        if (fifo_level != '0) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cnt_clr   = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        // The count reaches the limit on the same edge that enters ERR.
        if (lcd_busy) begin
          cnt_clr   = 1'b1;
          state_nxt = WAIT_DONE;
        end else if (tmo_inc == ACK_LIM) begin
          state_nxt = ERR;
        end
      end
      WAIT_DONE: begin
        // done is only looked at here, so a level left over from the
        // previous command cannot complete the next one early.
        if (!lcd_busy && lcd_done) begin
          done_ok   = 1'b1;
          state_nxt = READY;
        end else if (tmo_inc == DONE_LIM) begin
          state_nxt = ERR;
        end
      end
      ERR: begin
        if (err_clr) state_nxt = READY;
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Handshake timeout counter, shared by both wait states
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (cnt_clr) begin
      tmo_cnt <= '0;
    end else if (state == WAIT_ACK || state == WAIT_DONE) begin
      tmo_cnt <= tmo_inc;
    end
  end

  // Queue storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_legal) mem[wr_ptr] <= host_cmd;
  end

  // Pointers, occupancy, issue register and status counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      lcd_cmd       <= 4'd0;
      lcd_cmd_valid <= 1'b0;
      cmd_count     <= 8'd0;
      illegal_cmd   <= 1'b0;
    end else begin
      lcd_cmd_valid <= pop;
      illegal_cmd   <= push && !push_legal;

      if (push_legal) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        lcd_cmd <= mem[rd_ptr];
      end

      case ({push_legal, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase

      if (done_ok) cmd_count <= cmd_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// tb_lcd_cmd_sched: directed, table-driven bench for lcd_cmd_sched.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed from the scheduler's documented behaviour.
module tb_lcd_cmd_sched;

  logic       clk;
  logic       reset;
  logic [3:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic       lcd_busy;
  logic       lcd_done;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic [3:0] fifo_level;
  logic [7:0] cmd_count;
  logic       illegal_cmd;
  logic       timeout_err;
  logic       err_clr;
  logic       idle;

  int checks;
  int errors;

  lcd_cmd_sched #(
    .FIFO_DEPTH  (8),
    .ACK_TIMEOUT (15),
    .DONE_TIMEOUT(1023)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .host_cmd     (host_cmd),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .lcd_busy     (lcd_busy),
    .lcd_done     (lcd_done),
    .lcd_cmd      (lcd_cmd),
    .lcd_cmd_valid(lcd_cmd_valid),
    .fifo_level   (fifo_level),
    .cmd_count    (cmd_count),
    .illegal_cmd  (illegal_cmd),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr),
    .idle         (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cmd;
    logic       vld;
    logic       busy;
    logic       done;
    logic       clr;
    logic [3:0] e_cmd;
    logic       e_vld;
    logic [3:0] e_lvl;
    logic [7:0] e_cnt;
    logic       e_ill;
    logic       e_to;
    logic       e_idle;
    logic       e_rdy;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(int cmd, int vld, int busy, int done, int clr,
                              int e_cmd, int e_vld, int e_lvl, int e_cnt,
                              int e_ill, int e_to, int e_idle, int e_rdy);
    vec_t r;
    r.cmd    = 4'(cmd);
    r.vld    = 1'(vld);
    r.busy   = 1'(busy);
    r.done   = 1'(done);
    r.clr    = 1'(clr);
    r.e_cmd  = 4'(e_cmd);
    r.e_vld  = 1'(e_vld);
    r.e_lvl  = 4'(e_lvl);
    r.e_cnt  = 8'(e_cnt);
    r.e_ill  = 1'(e_ill);
    r.e_to   = 1'(e_to);
    r.e_idle = 1'(e_idle);
    r.e_rdy  = 1'(e_rdy);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv;
    int ni;
    logic [3:0] fill_cmds [7];

    checks = 0;
    errors = 0;

    // Idle scheduler: single command 4 with busy for 5 cycles, then done.
    vec.push_back(mk(4,1,0,0,0,  0,0,1,0,0,0,0,1));
    vec.push_back(mk(0,0,0,0,0,  4,1,0,0,0,0,0,1));
    vec.push_back(mk(0,0,0,0,0,  4,0,0,0,0,0,0,1));
    vec.push_back(mk(0,0,1,0,0,  4,0,0,0,0,0,0,1));
    vec.push_back(mk(0,0,1,0,0,  4,0,0,0,0,0,0,1));
    vec.push_back(mk(0,0,1,0,0,  4,0,0,0,0,0,0,1));
    vec.push_back(mk(0,0,1,0,0,  4,0,0,0,0,0,0,1));
    vec.push_back(mk(0,0,1,0,0,  4,0,0,0,0,0,0,1));
    vec.push_back(mk(0,0,0,1,0,  4,0,0,1,0,0,1,1));
    // Back-to-back pushes 1, 7, 9; first pop overlaps the second push.
    vec.push_back(mk(1,1,0,0,0,  4,0,1,1,0,0,0,1));
    vec.push_back(mk(7,1,0,0,0,  1,1,1,1,0,0,0,1));
    vec.push_back(mk(9,1,0,0,0,  1,0,2,1,0,0,0,1));
    vec.push_back(mk(0,0,1,0,0,  1,0,2,1,0,0,0,1));
    vec.push_back(mk(0,0,0,1,0,  1,0,2,2,0,0,0,1));
    // done stays high: must not complete command 7 early.
    vec.push_back(mk(0,0,0,1,0,  7,1,1,2,0,0,0,1));
    vec.push_back(mk(0,0,0,1,0,  7,0,1,2,0,0,0,1));
    vec.push_back(mk(0,0,0,1,0,  7,0,1,2,0,0,0,1));
    vec.push_back(mk(0,0,1,0,0,  7,0,1,2,0,0,0,1));
    vec.push_back(mk(0,0,1,1,0,  7,0,1,2,0,0,0,1));
    vec.push_back(mk(0,0,0,1,0,  7,0,1,3,0,0,0,1));
    vec.push_back(mk(0,0,0,0,0,  9,1,0,3,0,0,0,1));
    vec.push_back(mk(0,0,0,0,0,  9,0,0,3,0,0,0,1));
    vec.push_back(mk(0,0,1,0,0,  9,0,0,3,0,0,0,1));
    vec.push_back(mk(0,0,0,1,0,  9,0,0,4,0,0,1,1));
    // err_clr outside ERR has no effect.
    vec.push_back(mk(0,0,0,0,1,  9,0,0,4,0,0,1,1));

    fill_cmds = '{4'd5, 4'd6, 4'd8, 4'd10, 4'd11, 4'd0, 4'd1};

    reset      = 1'b1;
    host_cmd   = 4'd0;
    host_valid = 1'b0;
    lcd_busy   = 1'b1;
    lcd_done   = 1'b0;
    err_clr    = 1'b0;

    // Reset values
    step();
    step();
    chk("rst_host_ready", 32'(host_ready), 1);
    chk("rst_lcd_cmd", 32'(lcd_cmd), 0);
    chk("rst_cmd_valid", 32'(lcd_cmd_valid), 0);
    chk("rst_fifo_level", 32'(fifo_level), 0);
    chk("rst_cmd_count", 32'(cmd_count), 0);
    chk("rst_illegal", 32'(illegal_cmd), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_idle", 32'(idle), 0);

    // Boot: busy held for 70 cycles after release
    reset = 1'b0;
    nv = 0;
    ni = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (lcd_cmd_valid !== 1'b0) nv++;
      if (idle !== 1'b0) ni++;
    end
    chk("boot_valid_cycles", 32'(nv), 0);
    chk("boot_idle_cycles", 32'(ni), 0);
    lcd_busy = 1'b0;
    step();
    chk("boot_idle_after_busy", 32'(idle), 1);

    // Table-driven single-command and back-to-back traffic
    for (int i = 0; i < vec.size(); i++) begin
      host_cmd   = vec[i].cmd;
      host_valid = vec[i].vld;
      lcd_busy   = vec[i].busy;
      lcd_done   = vec[i].done;
      err_clr    = vec[i].clr;
      step();
      chk($sformatf("v%0d_lcd_cmd", i), 32'(lcd_cmd), 32'(vec[i].e_cmd));
      chk($sformatf("v%0d_cmd_valid", i), 32'(lcd_cmd_valid), 32'(vec[i].e_vld));
      chk($sformatf("v%0d_fifo_level", i), 32'(fifo_level), 32'(vec[i].e_lvl));
      chk($sformatf("v%0d_cmd_count", i), 32'(cmd_count), 32'(vec[i].e_cnt));
      chk($sformatf("v%0d_illegal", i), 32'(illegal_cmd), 32'(vec[i].e_ill));
      chk($sformatf("v%0d_timeout", i), 32'(timeout_err), 32'(vec[i].e_to));
      chk($sformatf("v%0d_idle", i), 32'(idle), 32'(vec[i].e_idle));
      chk($sformatf("v%0d_host_ready", i), 32'(host_ready), 32'(vec[i].e_rdy));
    end
    err_clr  = 1'b0;
    lcd_busy = 1'b0;
    lcd_done = 1'b0;

    // Fill with a stalled controller; illegal 13 in the middle. Edges numbered from here.
    host_valid = 1'b1;
    host_cmd   = 4'd2;
    step();                                    // edge 1: push 2
    chk("fill_lvl_first", 32'(fifo_level), 1);
    host_cmd = 4'd3;
    step();                                    // edge 2: pop 2, push 3; ISSUE cycle follows
    chk("fill_issue_valid", 32'(lcd_cmd_valid), 1);
    chk("fill_issue_cmd", 32'(lcd_cmd), 2);
    chk("fill_lvl_overlap", 32'(fifo_level), 1);
    host_cmd = 4'd13;
    step();                                    // edge 3: illegal push
    chk("illegal_pulse", 32'(illegal_cmd), 1);
    chk("illegal_lvl_same", 32'(fifo_level), 1);
    for (int j = 0; j < 7; j++) begin          // edges 4..10
      host_cmd = fill_cmds[j];
      step();
      chk($sformatf("fill_lvl_%0d", j), 32'(fifo_level), 32'(2 + j));
      if (j == 0) chk("illegal_one_cycle", 32'(illegal_cmd), 0);
      if (j == 5) chk("ready_at_7", 32'(host_ready), 1);
    end
    chk("full_host_ready", 32'(host_ready), 0);
    host_cmd = 4'd13;
    step();                                    // edge 11: offer while full
    chk("full_no_push_lvl", 32'(fifo_level), 8);
    chk("full_no_illegal", 32'(illegal_cmd), 0);
    host_valid = 1'b0;

    // Timeout: ISSUE cycle followed edge 2, so ERR is first seen after edge 18.
    repeat (6) step();                         // edge 17
    chk("timeout_not_yet", 32'(timeout_err), 0);
    step();                                    // edge 18
    chk("timeout_set", 32'(timeout_err), 1);
    repeat (3) step();
    chk("timeout_sticky", 32'(timeout_err), 1);
    chk("err_no_issue", 32'(lcd_cmd_valid), 0);
    chk("err_fifo_kept", 32'(fifo_level), 8);
    err_clr = 1'b1;
    step();
    chk("err_clr_timeout", 32'(timeout_err), 0);
    chk("err_clr_no_valid_yet", 32'(lcd_cmd_valid), 0);
    err_clr = 1'b0;
    step();
    chk("after_err_valid", 32'(lcd_cmd_valid), 1);
    chk("after_err_cmd", 32'(lcd_cmd), 3);
    chk("after_err_lvl", 32'(fifo_level), 7);
    chk("after_err_count", 32'(cmd_count), 4);

    // Reset in WAIT_DONE with commands queued
    step();                                    // WAIT_ACK
    lcd_busy = 1'b1;
    step();                                    // WAIT_DONE
    chk("pre_reset_lvl", 32'(fifo_level), 7);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_lvl", 32'(fifo_level), 0);
    chk("midrst_count", 32'(cmd_count), 0);
    chk("midrst_valid", 32'(lcd_cmd_valid), 0);
    chk("midrst_lcd_cmd", 32'(lcd_cmd), 0);
    chk("midrst_host_ready", 32'(host_ready), 1);
    step();
    reset    = 1'b0;
    lcd_busy = 1'b0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (lcd_cmd_valid !== 1'b0) nv++;
    end
    chk("postrst_valid_cycles", 32'(nv), 0);
    chk("postrst_lvl", 32'(fifo_level), 0);
    chk("postrst_idle", 32'(idle), 1);
    chk("postrst_count", 32'(cmd_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
